// File: rtl/bus_pkg.sv
// Shared types and constants for the bus memory responder.
// State encodings, strobe polarity and default wait states.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic ASSERTED_N = 1'b0;

  localparam int WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/bus_mem_array.sv
// Word-addressed storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module bus_mem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_mem_responder.sv
// Strobe-handshake memory slave with programmable wait states.
// Answers each as_n cycle with a one-clock ack_n pulse.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              as_n,
  input  logic              wr_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_n,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              aborted,
  output logic [7:0]        wr_count
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ack_n_q, ack_n_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              aborted_q, aborted_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic              commit;
  logic              we;
  logic [DATA_W-1:0] rdata;

  bus_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (data_in),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_n_d    = 1'b1;
    data_out_d = data_out_q;
    aborted_d  = 1'b0;
    wr_count_d = wr_count_q;
    commit     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (as_n == ASSERTED_N) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      ST_WAIT: begin
        if (as_n != ASSERTED_N) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          ack_n_d = 1'b0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: state_d = ST_HOLD;
      // Wait for strobe release so one strobe yields one ack.
      ST_HOLD: begin
        if (as_n != ASSERTED_N) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    we = commit && (wr_n == ASSERTED_N);
    if (we) begin
      wr_count_d = wr_count_q + 8'd1;
    end
    if (commit && (wr_n != ASSERTED_N)) begin
      data_out_d = rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      ack_n_q    <= 1'b1;
      data_out_q <= '0;
      aborted_q  <= 1'b0;
      wr_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_n_q    <= ack_n_d;
      data_out_q <= data_out_d;
      aborted_q  <= aborted_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign ack_n    = ack_n_q;
  assign data_out = data_out_q;
  assign busy     = (state_q != ST_IDLE);
  assign aborted  = aborted_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances
// driven by a master model and checked against a memory/count reference.
module tb_bus_mem_responder;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        as_n, wr_n;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic        ack_n, busy, aborted;
  logic [31:0] data_out;
  logic [7:0]  wr_count;

  logic        as_n0, wr_n0;
  logic [4:0]  addr0;
  logic [31:0] data0;
  logic        ack_n0, busy0, aborted0;
  logic [31:0] data_out0;
  logic [7:0]  wr_count0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_m [32];
  bit          vld_m [32];
  int          wc_m;
  logic [31:0] rd_m;
  bit          rd_known;

  always #5 clk = ~clk;

  bus_mem_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .reset(reset), .as_n(as_n), .wr_n(wr_n),
    .addr(addr), .data_in(data_in), .ack_n(ack_n),
    .data_out(data_out), .busy(busy), .aborted(aborted),
    .wr_count(wr_count)
  );

  bus_mem_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .as_n(as_n0), .wr_n(wr_n0),
    .addr(addr0), .data_in(data0), .ack_n(ack_n0),
    .data_out(data_out0), .busy(busy0), .aborted(aborted0),
    .wr_count(wr_count0)
  );

  // One master-driven cycle on the WC=2 instance; strobe kept low for
  // `hold` extra edges after the ack before release.
  task automatic run_cycle(input bit wr, input logic [4:0] a,
                           input logic [31:0] d, input int hold,
                           input string nm);
    @(negedge clk);
    as_n = 1'b0; wr_n = wr ? 1'b0 : 1'b1; addr = a; data_in = d;
    for (int e = 0; e <= WC + 1; e++) begin
      @(posedge clk); #1;
      if (e == WC + 1) begin
        if (wr) begin
          mem_m[a] = d; vld_m[a] = 1'b1; wc_m = (wc_m + 1) % 256;
        end else begin
          rd_known = vld_m[a];
          rd_m = mem_m[a];
        end
      end
      checks++;
      if (ack_n !== ((e == WC + 1) ? 1'b0 : 1'b1)) begin
        failures++;
        $display("FAIL %s ack_n edge%0d got=%b", nm, e, ack_n);
      end
      checks++;
      if (busy !== 1'b1 || aborted !== 1'b0) begin
        failures++;
        $display("FAIL %s busy/aborted edge%0d got=%b/%b want=1/0",
                 nm, e, busy, aborted);
      end
      checks++;
      if (wr_count !== 8'(wc_m)) begin
        failures++;
        $display("FAIL %s wr_count edge%0d got=%0d want=%0d",
                 nm, e, wr_count, wc_m);
      end
    end
    if (rd_known) begin
      checks++;
      if (data_out !== rd_m) begin
        failures++;
        $display("FAIL %s data_out got=%h want=%h", nm, data_out, rd_m);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      wr_n = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (ack_n !== 1'b1 || busy !== 1'b1 || wr_count !== 8'(wc_m)) begin
        failures++;
        $display("FAIL %s hold%0d ack_n/busy/wr_count got=%b/%b/%0d want=1/1/%0d",
                 nm, h, ack_n, busy, wr_count, wc_m);
      end
    end
    @(negedge clk);
    as_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || ack_n !== 1'b1) begin
      failures++;
      $display("FAIL %s release busy/ack_n got=%b/%b want=0/1",
               nm, busy, ack_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    as_n = 1'b1; wr_n = 1'b1; addr = '0; data_in = '0;
    as_n0 = 1'b1; wr_n0 = 1'b1; addr0 = '0; data0 = '0;
    #12;
    checks++;
    if (ack_n !== 1'b1 || busy !== 1'b0 || aborted !== 1'b0 ||
        data_out !== 32'd0 || wr_count !== 8'd0) begin
      failures++;
      $display("FAIL reset got ack=%b busy=%b ab=%b do=%h wc=%0d",
               ack_n, busy, aborted, data_out, wr_count);
    end
    checks++;
    if (ack_n0 !== 1'b1 || busy0 !== 1'b0 || wr_count0 !== 8'd0) begin
      failures++;
      $display("FAIL reset0 got ack=%b busy=%b wc=%0d",
               ack_n0, busy0, wr_count0);
    end
    @(negedge clk);
    reset = 1'b0;
    wc_m = 0; rd_m = 32'd0; rd_known = 1'b1;
  endtask

  task automatic test_write_read();
    run_cycle(1'b1, 5'd5, 32'hDEADBEEF, 0, "write5");
    run_cycle(1'b0, 5'd5, 32'h0, 0, "read5");
  endtask

  task automatic test_abort();
    int wc0;
    wc0 = wc_m;
    @(negedge clk);
    as_n = 1'b0; wr_n = 1'b0; addr = 5'd5; data_in = 32'hCAFEF00D;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      checks++;
      if (ack_n !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL abort_wait edge%0d ack/busy got=%b/%b", e, ack_n, busy);
      end
    end
    @(negedge clk);
    as_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (aborted !== 1'b1 || busy !== 1'b0 || ack_n !== 1'b1 ||
        wr_count !== 8'(wc0)) begin
      failures++;
      $display("FAIL abort_edge got ab=%b busy=%b ack=%b wc=%0d want 1/0/1/%0d",
               aborted, busy, ack_n, wr_count, wc0);
    end
    @(posedge clk); #1;
    checks++;
    if (aborted !== 1'b0 || ack_n !== 1'b1) begin
      failures++;
      $display("FAIL abort_pulse got ab=%b ack=%b want 0/1", aborted, ack_n);
    end
    run_cycle(1'b0, 5'd5, 32'h0, 0, "abort_readback");
  endtask

  task automatic test_strobe_held();
    run_cycle(1'b1, 5'd9, 32'h0BADF00D, 10, "held_write");
    run_cycle(1'b0, 5'd9, 32'h0, 10, "held_read");
  endtask

  task automatic test_reset_mid();
    run_cycle(1'b1, 5'd7, 32'hA5A55A5A, 0, "pre_reset_write");
    @(negedge clk);
    as_n = 1'b0; wr_n = 1'b0; addr = 5'd7; data_in = 32'h1234;
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++;
    if (ack_n !== 1'b1 || busy !== 1'b0 || wr_count !== 8'd0 ||
        data_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid got ack=%b busy=%b wc=%0d do=%h",
               ack_n, busy, wr_count, data_out);
    end
    @(negedge clk);
    as_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wc_m = 0; rd_m = 32'd0; rd_known = 1'b1;
    run_cycle(1'b0, 5'd7, 32'h0, 0, "reset_readback");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_cycle(1'($urandom), 5'($urandom), $urandom,
                int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_wrap();
    int e, extra;
    bit got;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      as_n0 = 1'b0; wr_n0 = 1'b0; addr0 = 5'($urandom); data0 = $urandom;
      got = 1'b0; e = 0;
      while (!got && e < 8) begin
        @(posedge clk); #1;
        if (ack_n0 === 1'b0) got = 1'b1;
        else e++;
      end
      checks++;
      if (!got || e != 1) begin
        failures++;
        $display("FAIL wrap_ack cycle%0d got_ack=%0d edge=%0d want edge 1",
                 i, got, e);
      end
      checks++;
      if (wr_count0 !== 8'(i + 1)) begin
        failures++;
        $display("FAIL wrap_count cycle%0d got=%0d want=%0d",
                 i, wr_count0, (i + 1) % 256);
      end
      @(negedge clk);
      as_n0 = 1'b1; wr_n0 = 1'b1;
      got = 1'b0; e = 0; extra = 0;
      while (!got && e < 6) begin
        @(posedge clk); #1;
        if (ack_n0 === 1'b0) extra++;
        if (busy0 === 1'b0) got = 1'b1;
        else e++;
      end
      checks++;
      if (!got || extra != 0 || e != 1) begin
        failures++;
        $display("FAIL wrap_term cycle%0d idle=%0d extra_acks=%0d edges=%0d",
                 i, got, extra, e);
      end
    end
    checks++;
    if (wr_count0 !== 8'd0) begin
      failures++;
      $display("FAIL wrap_final got=%0d want=0", wr_count0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_strobe_held();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
